// File: rtl/tuner_ctrl.sv
// Station-tuning controller: buttons -> DDS reload constant K and a BCD frequency readout.
// Optional hold-to-repeat stepping is built only when TUNER_AUTO_REPEAT_EN is defined.
module tuner_ctrl #(
    parameter int          width_dds = 32,
    parameter int          n_presets = 4,
    parameter int          f_min     = 875,
    parameter int          f_max     = 1080,
    parameter logic [63:0] K_base    = 64'd1565873493,
    parameter logic [63:0] K_step    = 64'd1789570,
    parameter int          rpt_delay = 16000,
    parameter int          rpt_rate  = 3200
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_store,
    input  logic                         btn_recall,
    input  logic [$clog2(n_presets)-1:0] sel,
    output logic [width_dds-1:0]         K,
    output logic [15:0]                  freq_bcd,
    output logic                         busy,
    output logic                         k_valid
);

    localparam int N     = f_max - f_min + 1;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(IDX_W + 1);
    localparam int SEL_W = $clog2(n_presets);

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
                else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (b) begin
                if (r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'd9;
                else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [15:0]          BCD_MIN    = to_bcd(f_min);
    localparam logic [15:0]          BCD_MAX    = to_bcd(f_max);
    localparam logic [63:0]          K_TOP_FULL = K_base + 64'(N - 1) * K_step;
    localparam logic [width_dds-1:0] K_BASE_W   = K_base[width_dds-1:0];
    localparam logic [width_dds-1:0] K_STEP_W   = K_step[width_dds-1:0];
    localparam logic [width_dds-1:0] K_TOP_W    = K_TOP_FULL[width_dds-1:0];
    localparam logic [IDX_W-1:0]     IDX_MAX    = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(IDX_W - 1);
    localparam logic [SEL_W:0]       NP         = (SEL_W + 1)'(n_presets);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                 state_reg;
    logic [width_dds-1:0]   k_reg, acc_reg, addend_reg;
    logic [15:0]            bcd_reg;
    logic [IDX_W-1:0]       idx_reg, mul_idx_reg;
    logic [CNT_W-1:0]       mul_cnt_reg;
    logic                   busy_reg, k_valid_reg;
    logic                   up_prev_reg, down_prev_reg, store_prev_reg, recall_prev_reg;
    logic [IDX_W-1:0]       preset_idx [n_presets];
    logic [15:0]            preset_bcd [n_presets];

    logic                   up_ev, down_ev, store_ev, recall_ev;
    logic                   step_up, step_down;
    logic [SEL_W-1:0]       sel_eff;

    assign up_ev     = en & btn_up     & ~up_prev_reg;
    assign down_ev   = en & btn_down   & ~down_prev_reg;
    assign store_ev  = en & btn_store  & ~store_prev_reg;
    assign recall_ev = en & btn_recall & ~recall_prev_reg;
    assign sel_eff   = ({1'b0, sel} < NP) ? sel : '0;

`ifdef TUNER_AUTO_REPEAT_EN
    localparam int RPT_MAX = (rpt_delay > rpt_rate) ? rpt_delay : rpt_rate;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic             rpt_phase_reg, rpt_hold, rpt_fire;

    assign rpt_hold     = btn_up ^ btn_down;
    assign rpt_cnt_next = rpt_cnt_reg + 1'b1;
    // The first repeat waits rpt_delay ticks after the press, later ones rpt_rate.
    assign rpt_fire = en & rpt_hold & ~busy_reg & ~up_ev & ~down_ev &
                      (rpt_cnt_next == (rpt_phase_reg ? RPT_W'(rpt_rate) : RPT_W'(rpt_delay)));

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_reg   <= '0;
            rpt_phase_reg <= 1'b0;
        end else if (en) begin
            if (!rpt_hold || busy_reg || up_ev || down_ev) begin
                rpt_cnt_reg   <= '0;
                rpt_phase_reg <= 1'b0;
            end else if (rpt_fire) begin
                rpt_cnt_reg   <= '0;
                rpt_phase_reg <= 1'b1;
            end else begin
                rpt_cnt_reg   <= rpt_cnt_next;
            end
        end
    end
`endif

    always_comb begin
        step_up   = 1'b0;
        step_down = 1'b0;
        if (up_ev && !down_ev) step_up = 1'b1;
        else if (down_ev && !up_ev) step_down = 1'b1;
`ifdef TUNER_AUTO_REPEAT_EN
        else if (rpt_fire) begin
            step_up   = btn_up;
            step_down = btn_down;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            k_reg           <= K_BASE_W;
            acc_reg         <= K_BASE_W;
            addend_reg      <= K_STEP_W;
            bcd_reg         <= BCD_MIN;
            idx_reg         <= '0;
            mul_idx_reg     <= '0;
            mul_cnt_reg     <= '0;
            busy_reg        <= 1'b0;
            k_valid_reg     <= 1'b0;
            up_prev_reg     <= 1'b0;
            down_prev_reg   <= 1'b0;
            store_prev_reg  <= 1'b0;
            recall_prev_reg <= 1'b0;
            for (int i = 0; i < n_presets; i++) begin
                preset_idx[i] <= '0;
                preset_bcd[i] <= BCD_MIN;
            end
        end else begin
            k_valid_reg <= 1'b0;
            if (en) begin
                up_prev_reg     <= btn_up;
                down_prev_reg   <= btn_down;
                store_prev_reg  <= btn_store;
                recall_prev_reg <= btn_recall;
            end
            case (state_reg)
                S_IDLE: begin
                    if (recall_ev) begin
                        idx_reg     <= preset_idx[sel_eff];
                        bcd_reg     <= preset_bcd[sel_eff];
                        mul_idx_reg <= preset_idx[sel_eff];
                        acc_reg     <= K_BASE_W;
                        addend_reg  <= K_STEP_W;
                        mul_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= S_MUL;
                    end else if (store_ev) begin
                        preset_idx[sel_eff] <= idx_reg;
                        preset_bcd[sel_eff] <= bcd_reg;
                    end else if (step_up) begin
                        k_valid_reg <= 1'b1;
                        if (idx_reg == IDX_MAX) begin
                            idx_reg <= '0;
                            k_reg   <= K_BASE_W;
                            bcd_reg <= BCD_MIN;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                            k_reg   <= k_reg + K_STEP_W;
                            bcd_reg <= bcd_inc(bcd_reg);
                        end
                    end else if (step_down) begin
                        k_valid_reg <= 1'b1;
                        if (idx_reg == '0) begin
                            idx_reg <= IDX_MAX;
                            k_reg   <= K_TOP_W;
                            bcd_reg <= BCD_MAX;
                        end else begin
                            idx_reg <= idx_reg - 1'b1;
                            k_reg   <= k_reg - K_STEP_W;
                            bcd_reg <= bcd_dec(bcd_reg);
                        end
                    end
                end
                // LSB-first shift-add: K = K_base + idx * K_step, one index bit per cycle.
                S_MUL: begin
                    acc_reg     <= acc_reg + (mul_idx_reg[0] ? addend_reg : '0);
                    addend_reg  <= addend_reg << 1;
                    mul_idx_reg <= mul_idx_reg >> 1;
                    mul_cnt_reg <= mul_cnt_reg + 1'b1;
                    if (mul_cnt_reg == CNT_LAST) state_reg <= S_DONE;
                end
                S_DONE: begin
                    k_reg       <= acc_reg;
                    k_valid_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign K        = k_reg;
    assign freq_bcd = bcd_reg;
    assign busy     = busy_reg;
    assign k_valid  = k_valid_reg;

endmodule
